// File: rtl/axi_default_slave_wr.sv
// Default AXI write slave for unmapped addresses: accepts AW, drains the W burst,
// answers with a single DECERR response and counts completed error responses.
module axi_default_slave_wr #(
  parameter int IDW   = 8,
  parameter int LENW  = 4,
  parameter int DATAW = 32,
  parameter int CNTW  = 16
) (
  input  logic               i_aclk,
  input  logic               i_aresetn,
  input  logic [IDW-1:0]     i_awid,
  input  logic [LENW-1:0]    i_awlen,
  input  logic               i_awvalid,
  output logic               o_awready,
  input  logic [DATAW-1:0]   i_wdata,
  input  logic [DATAW/8-1:0] i_wstrb,
  input  logic               i_wlast,
  input  logic               i_wvalid,
  output logic               o_wready,
  output logic [IDW-1:0]     o_bid,
  output logic [1:0]         o_bresp,
  output logic               o_bvalid,
  input  logic               i_bready,
  output logic [CNTW-1:0]    o_decerr_cnt
);

  // state | meaning
  // IDLE  | waiting for an AW handshake
  // DRAIN | swallowing W beats until WLAST or len+1 beats
  // RESP  | holding the DECERR B response until BREADY
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_DECERR = 2'b11;
  localparam logic [LENW:0] BEAT_ONE    = {{LENW{1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};

  logic [1:0]      r_state;
  logic [IDW-1:0]  r_id;
  logic [LENW-1:0] r_len;
  logic [LENW:0]   r_beat;
  logic [CNTW-1:0] r_cnt;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_last_beat;
  logic w_unused_wr_payload;

  // Write data is discarded; reduce it so it is visibly consumed.
  assign w_unused_wr_payload = ^{i_wdata, i_wstrb};

  assign o_awready = (r_state == S_IDLE);
  assign o_wready  = (r_state == S_DRAIN);
  assign o_bvalid  = (r_state == S_RESP);
  assign o_bid     = r_id;
  assign o_bresp   = (r_state == S_RESP) ? RESP_DECERR : RESP_OKAY;
  assign o_decerr_cnt = r_cnt;

  assign w_aw_hs     = o_awready & i_awvalid;
  assign w_w_hs      = o_wready & i_wvalid;
  assign w_b_hs      = o_bvalid & i_bready;
  assign w_last_beat = (r_beat == {1'b0, r_len});

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_aw_hs) begin
            r_id    <= i_awid;
            r_len   <= i_awlen;
            r_beat  <= '0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_w_hs) begin
            r_beat <= r_beat + BEAT_ONE;
            // Whichever comes first ends the burst: WLAST or the beat count implied by AWLEN.
            if (i_wlast || w_last_beat) begin
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (w_b_hs) begin
            r_state <= S_IDLE;
            if (r_cnt != '1) begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_default_slave_wr.sv
// Self-checking bench for axi_default_slave_wr: directed vector table, hand sequences
// and randomized transactions against a transaction-level expectation model.
module tb_axi_default_slave_wr;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [7:0]  awid;
  logic [3:0]  awlen;
  logic        awvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        bready;

  logic        awready, wready, bvalid;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic [15:0] decerr_cnt;

  logic        awready2, wready2, bvalid2;
  logic [7:0]  bid2;
  logic [1:0]  bresp2;
  logic [1:0]  decerr_cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  axi_default_slave_wr dut (
    .i_aclk(clk), .i_aresetn(aresetn),
    .i_awid(awid), .i_awlen(awlen), .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
    .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
    .o_decerr_cnt(decerr_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used to observe saturation.
  axi_default_slave_wr #(.CNTW(2)) dut_sat (
    .i_aclk(clk), .i_aresetn(aresetn),
    .i_awid(awid), .i_awlen(awlen), .i_awvalid(awvalid), .o_awready(awready2),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready2),
    .o_bid(bid2), .o_bresp(bresp2), .o_bvalid(bvalid2), .i_bready(bready),
    .o_decerr_cnt(decerr_cnt2)
  );

  typedef struct {
    int id;
    int len;
    int wlast_pos;   // accepted-beat index carrying WLAST; 255 = never
    bit gaps;
    int bhold;
    int exp_beats;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_beats(input int len, input int wlast_pos);
    return (wlast_pos <= len) ? wlast_pos + 1 : len + 1;
  endfunction

  task automatic aw_phase(input int id, input int len);
    int t = 0;
    awvalid = 1'b1;
    awid    = id[7:0];
    awlen   = len[3:0];
    while (!awready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("aw_ready_wait", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    chk("wready_after_aw", wready, 1);
    chk("awready_after_aw", awready, 0);
  endtask

  task automatic w_phase(input int id, input int wlast_pos, input bit gaps, input int exp_beats);
    int acc = 0;
    int last_hs = -10;
    int c;
    bit v;
    for (c = 0; c < 100; c++) begin
      if (!wready) break;
      chk("awready_in_drain", awready, 0);
      v = (gaps && c < 50) ? bit'($urandom_range(0, 1)) : 1'b1;
      wvalid = v;
      wlast  = (acc == wlast_pos);
      wdata  = $urandom;
      wstrb  = 4'($urandom);
      if (v) begin
        acc++;
        last_hs = c;
      end
      @(negedge clk);
    end
    chk("w_beats", acc, exp_beats);
    chk("bvalid_latency", c, last_hs + 1);
    chk("bvalid_set", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp_decerr", bresp, 2'b11);
    // A stray beat stays presented through RESP and must not be taken.
    wvalid = 1'b1;
    wlast  = 1'b0;
  endtask

  task automatic b_phase(input int id, input int bhold);
    for (int i = 0; i < bhold; i++) begin
      bready = 1'b0;
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1);
      chk("bid_hold", bid, id);
      chk("bresp_hold", bresp, 2'b11);
      chk("wready_in_resp", wready, 0);
      chk("awready_in_resp", awready, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    exp_cnt++;
    chk("bvalid_clear", bvalid, 0);
    chk("awready_after_b", awready, 1);
    chk("wready_after_b", wready, 0);
    chk("bresp_idle", bresp, 2'b00);
    chk("bid_idle_hold", bid, id);
    chk("decerr_cnt", decerr_cnt, exp_cnt);
    chk("decerr_cnt_sat", decerr_cnt2, (exp_cnt > 3) ? 3 : exp_cnt);
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic run_txn(input int id, input int len, input int wlast_pos, input bit gaps, input int bhold);
    aw_phase(id, len);
    w_phase(id, wlast_pos, gaps, model_beats(len, wlast_pos));
    b_phase(id, bhold);
  endtask

  initial begin
    vecs[0] = '{id: 'h35, len: 0,  wlast_pos: 0,   gaps: 0, bhold: 0, exp_beats: 1};
    vecs[1] = '{id: 'hA1, len: 3,  wlast_pos: 3,   gaps: 1, bhold: 3, exp_beats: 4};
    vecs[2] = '{id: 'h5C, len: 3,  wlast_pos: 1,   gaps: 0, bhold: 1, exp_beats: 2};
    vecs[3] = '{id: 'h7E, len: 1,  wlast_pos: 255, gaps: 0, bhold: 2, exp_beats: 2};
    vecs[4] = '{id: 'h00, len: 15, wlast_pos: 15,  gaps: 1, bhold: 1, exp_beats: 16};
    vecs[5] = '{id: 'hFF, len: 2,  wlast_pos: 0,   gaps: 1, bhold: 0, exp_beats: 1};

    aresetn = 1'b0;
    awid = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_bid", bid, 0);
    chk("rst_cnt", decerr_cnt, 0);

    // A W beat presented in IDLE must wait.
    wvalid = 1'b1;
    @(negedge clk);
    chk("idle_wready", wready, 0);
    wvalid = 1'b0;

    foreach (vecs[i]) begin
      chk("vec_model", model_beats(vecs[i].len, vecs[i].wlast_pos), vecs[i].exp_beats);
      aw_phase(vecs[i].id, vecs[i].len);
      w_phase(vecs[i].id, vecs[i].wlast_pos, vecs[i].gaps, vecs[i].exp_beats);
      b_phase(vecs[i].id, vecs[i].bhold);
    end

    // Back-to-back: second AW pending from DRAIN until after the first B handshake.
    aw_phase('h11, 1);
    awvalid = 1'b1;
    awid    = 8'h22;
    awlen   = 4'd0;
    w_phase('h11, 1, 0, 2);
    b_phase('h11, 2);
    aw_phase('h22, 0);
    w_phase('h22, 0, 0, 1);
    b_phase('h22, 0);

    for (int n = 0; n < 30; n++) begin
      int id, len, sel, wp;
      id  = int'($urandom_range(0, 255));
      len = int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 3));
      wp  = (sel < 2) ? len : (sel == 2) ? int'($urandom_range(0, len)) : 255;
      run_txn(id, len, wp, bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Reset mid-DRAIN after two of four beats.
    aw_phase('h44, 3);
    wvalid = 1'b1;
    wlast  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wvalid  = 1'b0;
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    exp_cnt = 0;
    chk("midrst_awready", awready, 1);
    chk("midrst_wready", wready, 0);
    chk("midrst_bvalid", bvalid, 0);
    chk("midrst_bid", bid, 0);
    chk("midrst_cnt", decerr_cnt, 0);
    @(negedge clk);
    chk("midrst_no_b", bvalid, 0);
    run_txn('h66, 2, 2, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
